// File: rtl/if_fetch_stage_pkg.sv
// Shared IF-stage definitions: fetch FSM states, PC source select, reset/trap defaults.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_EXC_VECTOR = 32'h8000_0180;
  localparam logic [XLEN-1:0] DEF_NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD    = 2'd0,
    PC_SEQ     = 2'd1,
    PC_TARGET  = 2'd2,
    PC_PENDING = 2'd3
  } pc_sel_e;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset > bubble > load > hold.
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc4_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc4,
  output logic            valid
);

  // A bubble keeps the last pc4 so ID never sees a spurious address change.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, imem handshake FSM and IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [XLEN-1:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [XLEN-1:0] NOP_INSTR  = DEF_NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCWrite,
  input  logic            IF_ID_WRITE,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            exception,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc4,
  output logic            if_id_valid
);

  fetch_state_e    state;
  fetch_state_e    state_next;
  pc_sel_e         pc_sel;
  logic            ifid_load;
  logic            ifid_bubble;
  logic            pend_load;
  logic [XLEN-1:0] pending_pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] flush_target;
  logic            flush;
  logic            advance;

  assign flush        = exception | redirect;
  assign advance      = PCWrite & IF_ID_WRITE;
  assign pc_plus4     = pc + XLEN'(4);
  assign flush_target = exception ? EXC_VECTOR : align_word(redirect_pc);

  // PC only moves at a request boundary, so it doubles as the held fetch address.
  assign imem_addr = pc;
  assign imem_req  = ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FETCH: begin
        if (!flush && !imem_ready) state_next = WAIT;
      end
      WAIT: begin
        if (imem_ready)  state_next = FETCH;
        else if (flush)  state_next = DISCARD;
      end
      DISCARD: begin
        if (imem_ready) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Control decode: flush beats stall; a squashed request retires into pending_pc.
  always_comb begin
    pc_sel      = PC_HOLD;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    pend_load   = 1'b0;
    unique case (state)
      FETCH: begin
        if (flush) begin
          pc_sel      = PC_TARGET;
          ifid_bubble = 1'b1;
        end else if (!imem_ready) begin
          ifid_bubble = IF_ID_WRITE;
        end else if (advance) begin
          pc_sel    = PC_SEQ;
          ifid_load = 1'b1;
        end
      end
      WAIT: begin
        if (flush) begin
          ifid_bubble = 1'b1;
          if (imem_ready) pc_sel = PC_TARGET;
          else            pend_load = 1'b1;
        end else if (!imem_ready) begin
          ifid_bubble = IF_ID_WRITE;
        end else if (advance) begin
          pc_sel    = PC_SEQ;
          ifid_load = 1'b1;
        end
      end
      DISCARD: begin
        ifid_bubble = 1'b1;
        pend_load   = flush;
        if (imem_ready) pc_sel = flush ? PC_TARGET : PC_PENDING;
      end
      default: begin
        ifid_bubble = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      unique case (pc_sel)
        PC_SEQ:     pc <= pc_plus4;
        PC_TARGET:  pc <= flush_target;
        PC_PENDING: pc <= pending_pc;
        default:    pc <= pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_pc <= '0;
    end else if (pend_load) begin
      pending_pc <= flush_target;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .instr_in (imem_rdata),
    .pc4_in   (pc_plus4),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed scenarios then random traffic vs a behavioural model.
module tb_if_fetch_stage;

  localparam logic [31:0] EXC_VEC = 32'h8000_0180;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite;
  logic        IF_ID_WRITE;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exception;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        chk_pc4;
    logic        req;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: abstract "request outstanding" / "request squashed" flags.
  logic [31:0] m_pc, m_instr, m_pc4, m_pend;
  logic        m_valid, m_busy, m_squash;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .PCWrite     (PCWrite),
    .IF_ID_WRITE (IF_ID_WRITE),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .exception   (exception),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bubble();
    m_instr = NOP;
    m_valid = 1'b0;
  endtask

  // Applies one cycle of inputs and predicts the state after the next rising edge.
  task automatic step(input bit rst, input bit pcw, input bit ifw, input bit rd,
                      input logic [31:0] rpc, input bit ex, input bit rdy);
    logic [31:0] tgt;
    bit          fl;
    exp_t        e;
    @(negedge clk);
    reset       = rst;
    PCWrite     = pcw;
    IF_ID_WRITE = ifw;
    redirect    = rd;
    redirect_pc = rpc;
    exception   = ex;
    imem_ready  = rdy;
    fl  = rd | ex;
    tgt = ex ? EXC_VEC : {rpc[31:2], 2'b00};
    if (rst) begin
      m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
      m_busy = 1'b0; m_squash = 1'b0; m_pend = 32'h0;
    end else if (m_squash) begin
      bubble();
      if (fl) m_pend = tgt;
      if (rdy) begin
        m_pc     = m_pend;
        m_squash = 1'b0;
        m_busy   = 1'b0;
      end
    end else if (fl) begin
      bubble();
      if (m_busy && !rdy) begin
        m_squash = 1'b1;
        m_pend   = tgt;
      end else begin
        m_pc   = tgt;
        m_busy = 1'b0;
      end
    end else if (!rdy) begin
      m_busy = 1'b1;
      if (ifw) bubble();
    end else begin
      m_busy = 1'b0;
      if (pcw && ifw) begin
        m_instr = mem_word(m_pc);
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
    e.pc      = m_pc;
    e.instr   = m_instr;
    e.pc4     = m_pc4;
    e.valid   = m_valid;
    e.chk_pc4 = m_valid | rst;
    e.req     = ~rst;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 0, 32'h0, 0, 1);
  endtask

  // Monitor: compares each DUT state after the edge against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("pc", pc, e.pc);
        cmp("imem_addr", imem_addr, e.pc);
        cmp("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
        cmp("if_id_instr", if_id_instr, e.instr);
        if (e.chk_pc4) cmp("if_id_pc4", if_id_pc4, e.pc4);
        cmp("imem_req", {31'b0, imem_req}, {31'b0, e.req});
      end
    end
  end

  initial begin
    bit stall, rst, rd, ex, rdy, ifw;
    reset = 1'b1; PCWrite = 1'b1; IF_ID_WRITE = 1'b1; redirect = 1'b0;
    redirect_pc = 32'h0; exception = 1'b0; imem_ready = 1'b1;

    // Reset, then sequential fetch of words @0, @4.
    step(1, 1, 1, 0, 32'h0, 0, 1);
    step(1, 1, 1, 0, 32'h0, 0, 1);
    @(posedge clk); #2;
    cmp("reset_pc", pc, 32'h0);
    cmp("reset_valid", {31'b0, if_id_valid}, 32'h0);
    run(2);
    // Load-use stall at pc=8, then @8 loads.
    step(0, 0, 0, 0, 32'h0, 0, 1);
    run(2);
    // Redirect with misaligned target at pc=0x10.
    step(0, 1, 1, 1, 32'h0000_0043, 0, 1);
    @(posedge clk); #2;
    cmp("redirect_pc", pc, 32'h0000_0040);
    cmp("redirect_bubble", {31'b0, if_id_valid}, 32'h0);
    run(1);
    // Wait at 0x20, redirect mid-wait, reply dropped.
    step(0, 1, 1, 1, 32'h0000_0020, 0, 1);
    step(0, 1, 1, 0, 32'h0, 0, 0);
    step(0, 1, 1, 1, 32'h0000_0100, 0, 0);
    step(0, 1, 1, 0, 32'h0, 0, 0);
    step(0, 1, 1, 0, 32'h0, 0, 1);
    @(posedge clk); #2;
    cmp("discard_pc", pc, 32'h0000_0100);
    cmp("discard_valid", {31'b0, if_id_valid}, 32'h0);
    run(1);
    // Exception + redirect + stall together.
    step(0, 0, 1, 1, 32'h0000_0200, 1, 1);
    @(posedge clk); #2;
    cmp("exc_pc", pc, EXC_VEC);
    run(1);
    // Reset during WAIT.
    step(0, 1, 1, 1, 32'h0000_0030, 0, 1);
    step(0, 1, 1, 0, 32'h0, 0, 0);
    step(1, 1, 1, 0, 32'h0, 0, 0);
    step(0, 1, 1, 0, 32'h0, 0, 1);
    // PC wrap-around.
    step(0, 1, 1, 1, 32'hFFFF_FFFC, 0, 1);
    run(1);
    @(posedge clk); #2;
    cmp("wrap_pc", pc, 32'h0);
    cmp("wrap_pc4", if_id_pc4, 32'h0);
    cmp("wrap_valid", {31'b0, if_id_valid}, 32'h1);

    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 15);
      ifw   = !stall;
      if ($urandom_range(0, 99) < 5) ifw = ~ifw;
      rd    = ($urandom_range(0, 99) < 10);
      ex    = ($urandom_range(0, 99) < 4);
      rdy   = ($urandom_range(0, 99) < 70);
      step(rst, !stall, ifw, rd, $urandom, ex, rdy);
    end

    repeat (3) @(posedge clk);
    #2;
    cmp("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
